// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port: single-cycle request/acknowledge with a read-data return.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-word hold buffer for stalls, and the IF/ID pipeline register.
//
// state  | meaning
// S_REQ  | request at PC; a word acked during a stall is parked in the hold buffer
// S_HOLD | no request; hold buffer owns the next word until the stall releases
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freez,
    input  logic               brTaken,
    input  logic [31:0]        brAddr,
    fetch_stage_if.master      bus,
    output logic [31:0]        instruction,
    output logic [31:0]        PCOut,
    output logic               flushOut
);
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef enum logic {S_REQ, S_HOLD} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] hold_buf, hold_buf_d;
    logic [31:0] instr_d, pcout_d;
    logic        flush_d;
    logic [31:0] pc_plus4;

    assign pc_plus4      = pc + 32'd4;
    assign bus.imem_addr = pc;
    // gated by rst so the request drops asynchronously with reset
    assign bus.imem_req  = rst && (state == S_REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC_W;
            hold_buf    <= 32'd0;
            instruction <= 32'd0;
            PCOut       <= 32'd0;
            flushOut    <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            hold_buf    <= hold_buf_d;
            instruction <= instr_d;
            PCOut       <= pcout_d;
            flushOut    <= flush_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        hold_buf_d = hold_buf;
        instr_d    = instruction;
        pcout_d    = PCOut;
        flush_d    = flushOut;

        if (brTaken) begin
            // redirect wins over stall and ack; any parked or in-flight word is dropped
            state_d    = S_REQ;
            pc_d       = brAddr & 32'hFFFF_FFFC;
            hold_buf_d = 32'd0;
            instr_d    = 32'd0;
            pcout_d    = 32'd0;
            flush_d    = 1'b1;
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        if (freez) begin
                            hold_buf_d = bus.imem_rdata;
                            state_d    = S_HOLD;
                        end else begin
                            instr_d = bus.imem_rdata;
                            pcout_d = pc_plus4;
                            flush_d = 1'b0;
                            pc_d    = pc_plus4;
                        end
                    end else if (!freez) begin
                        instr_d = 32'd0;
                        pcout_d = 32'd0;
                        flush_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freez) begin
                        instr_d = hold_buf;
                        pcout_d = pc_plus4;
                        flush_d = 1'b0;
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: IF/ID expectations queued per step and popped after the edge.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        freez;
    logic        brTaken;
    logic [31:0] brAddr;
    logic        ack;

    logic [31:0] instr0, pcout0, instr1, pcout1;
    logic        flush0, flush1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        flush;
    } exp_t;

    exp_t sb[$];

    fetch_stage_if bus0 ();
    fetch_stage_if bus1 ();

    assign bus0.imem_ack   = ack;
    assign bus0.imem_rdata = bus0.imem_addr | 32'hA000_0000;
    assign bus1.imem_ack   = ack;
    assign bus1.imem_rdata = bus1.imem_addr | 32'hA000_0000;

    fetch_stage dut0 (
        .clk(clk), .rst(rst), .freez(freez), .brTaken(brTaken), .brAddr(brAddr),
        .bus(bus0), .instruction(instr0), .PCOut(pcout0), .flushOut(flush0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .freez(freez), .brTaken(brTaken), .brAddr(brAddr),
        .bus(bus1), .instruction(instr1), .PCOut(pcout1), .flushOut(flush1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check the request presented this cycle, then the IF/ID result after the edge.
    task automatic step(input logic fz, input logic br, input logic [31:0] ba, input logic ak,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                        input logic exp_flush);
        exp_t e;
        freez   = fz;
        brTaken = br;
        brAddr  = ba;
        ack     = ak;
        chk("imem_req", {31'd0, bus0.imem_req}, {31'd0, exp_req});
        chk("imem_addr", bus0.imem_addr, exp_addr);
        e.instr = exp_instr;
        e.pc    = exp_pc;
        e.flush = exp_flush;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("instruction", instr0, e.instr);
            chk("PCOut", pcout0, e.pc);
            chk("flushOut", {31'd0, flush0}, {31'd0, e.flush});
        end
    endtask

    initial begin
        rst     = 1'b0;
        freez   = 1'b0;
        brTaken = 1'b0;
        brAddr  = 32'd0;
        ack     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instruction", instr0, 32'd0);
        chk("rst_PCOut", pcout0, 32'd0);
        chk("rst_flushOut", {31'd0, flush0}, 32'd0);
        chk("rst_imem_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("rst_imem_addr", bus0.imem_addr, 32'd0);
        chk("rst_imem_addr_hi", bus1.imem_addr, 32'hFFFF_FFFC);
        rst = 1'b1;
        #1;

        // sequential fetch straight out of reset; wrap check on the high-reset instance
        step(0, 0, 0, 1, 1, 32'h0, 32'hA000_0000, 32'h4, 0);
        chk("wrap_instruction", instr1, 32'hFFFF_FFFC);
        chk("wrap_PCOut", pcout1, 32'h0);
        chk("wrap_imem_addr", bus1.imem_addr, 32'h0);
        step(0, 0, 0, 1, 1, 32'h4, 32'hA000_0004, 32'h8, 0);
        step(0, 0, 0, 1, 1, 32'h8, 32'hA000_0008, 32'hC, 0);

        // misaligned redirect back to 8
        step(0, 1, 32'h9, 1, 1, 32'hC, 32'h0, 32'h0, 1);

        // stall coinciding with ack at PC=8; held register keeps the flush flag
        step(1, 0, 0, 1, 1, 32'h8, 32'h0, 32'h0, 1);
        step(1, 0, 0, 1, 0, 32'h8, 32'h0, 32'h0, 1);
        step(0, 0, 0, 1, 0, 32'h8, 32'hA000_0008, 32'hC, 0);
        step(0, 0, 0, 1, 1, 32'hC, 32'hA000_000C, 32'h10, 0);

        // redirect during stall
        step(1, 1, 32'h43, 1, 1, 32'h10, 32'h0, 32'h0, 1);
        step(0, 0, 0, 1, 1, 32'h40, 32'hA000_0040, 32'h44, 0);

        // memory not acking: bubbles with stable address
        step(0, 0, 0, 0, 1, 32'h44, 32'h0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h44, 32'h0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h44, 32'h0, 32'h0, 0);
        step(0, 0, 0, 1, 1, 32'h44, 32'hA000_0044, 32'h48, 0);

        // no ack while stalled holds outputs; then park a word and redirect it away
        step(1, 0, 0, 0, 1, 32'h48, 32'hA000_0044, 32'h48, 0);
        step(1, 0, 0, 1, 1, 32'h48, 32'hA000_0044, 32'h48, 0);
        step(0, 1, 32'h100, 1, 0, 32'h48, 32'h0, 32'h0, 1);
        step(0, 0, 0, 1, 1, 32'h100, 32'hA000_0100, 32'h104, 0);

        // asynchronous reset while a word is parked
        step(1, 0, 0, 1, 1, 32'h104, 32'hA000_0100, 32'h104, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_instruction", instr0, 32'd0);
        chk("async_PCOut", pcout0, 32'd0);
        chk("async_flushOut", {31'd0, flush0}, 32'd0);
        chk("async_imem_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("async_imem_addr", bus0.imem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        freez = 1'b0;
        #1;
        step(0, 0, 0, 1, 1, 32'h0, 32'hA000_0000, 32'h4, 0);
        step(0, 0, 0, 1, 1, 32'h4, 32'hA000_0004, 32'h8, 0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset; its low two bits SHALL be zero.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port freez, input, 1 bit: hazard stall; when 1, the IF/ID register holds.
REQ-005 The block SHALL have port brTaken, input, 1 bit: branch/jump resolved taken in EXE.
REQ-006 The block SHALL have port brAddr, input, 32 bits: branch target byte address.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: byte address of the fetch, equal to the current PC.
REQ-009 The block SHALL have port imem_ack, input, 1 bit: imem_rdata is valid for the imem_addr presented in the same cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-011 The block SHALL have port instruction, output, 32 bits: registered IF/ID instruction, feeding the ID stage.
REQ-012 The block SHALL have port PCOut, output, 32 bits: registered PC+4 of that instruction.
REQ-013 The block SHALL have port flushOut, output, 1 bit: registered bubble-from-redirect flag, feeding ID flushIn.

Function
REQ-014 The block SHALL hold internal state: PC (32 bits), hold buffer (32 bits), and a 2-state FSM {S_REQ, S_HOLD}.
REQ-015 The memory transaction SHALL be single-cycle: no request outstanding across cycles, so imem_addr may change in any cycle.
REQ-016 In S_REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC.
REQ-017 In S_HOLD, imem_req SHALL be 0.
REQ-018 In S_REQ with imem_ack=1, freez=0 and brTaken=0, the block SHALL, at the clock edge:
  - load instruction with imem_rdata;
  - load PCOut with PC+4;
  - clear flushOut to 0;
  - advance PC to PC+4;
  - remain in S_REQ.
REQ-019 In S_REQ with imem_ack=1, freez=1 and brTaken=0, the block SHALL:
  - capture imem_rdata into the hold buffer;
  - leave PC and the IF/ID outputs unchanged;
  - go to S_HOLD.
REQ-020 In S_REQ with imem_ack=0 and brTaken=0:
  - with freez=0, the block SHALL load a NOP bubble (instruction=0, PCOut=0, flushOut=0);
  - with freez=1, the block SHALL hold the outputs;
  - in both cases PC SHALL be unchanged.
REQ-021 In S_HOLD with freez=0 and brTaken=0, the block SHALL:
  - load instruction with the hold buffer;
  - load PCOut with PC+4 and clear flushOut;
  - advance PC to PC+4;
  - go to S_REQ, with no refetch of the held word.
REQ-022 In S_HOLD with freez=1 and brTaken=0, all state SHALL be held.
REQ-023 brTaken=1 SHALL have highest priority in either state, regardless of freez or imem_ack. At the clock edge the block SHALL:
  - load PC with {brAddr[31:2],2'b00};
  - load instruction=0, PCOut=0, flushOut=1;
  - discard the hold buffer and any same-cycle imem_rdata;
  - go to S_REQ.
REQ-024 flushOut SHALL be 1 only for the single IF/ID load caused by a redirect; any later IF/ID load SHALL clear it, and a held register SHALL keep it.
REQ-025 PC+4 SHALL wrap modulo 2^32 with no error indication.
REQ-026 Each fetched word SHALL be delivered to IF/ID exactly once, in program order, with no duplication or loss across stalls.

Reset
REQ-027 While rst=0, the block SHALL asynchronously force:
  - PC=RESET_PC, hold buffer=0, FSM=S_REQ;
  - instruction=0, PCOut=0, flushOut=0;
  - imem_req=0.
REQ-028 Reset asserted mid-operation, including in S_HOLD, SHALL discard the buffered word.
REQ-029 On the first clock edge after rst rises, the block SHALL operate per REQ-016..REQ-026 with no extra idle cycle.

Verification
REQ-030 Reset release, imem_ack=1, rdata=addr|0xA000_0000 -> IF/ID shows 0xA000_0000/4, then 0xA000_0004/8, then 0xA000_0008/12; flushOut=0.
REQ-031 freez=1 for 2 cycles coinciding with an ack at PC=8 -> imem_req=0 for 2 cycles and IF/ID is held; after release, word 0xA000_0008 with PCOut=12 is delivered once and imem_addr then shows 12.
REQ-032 brTaken=1, brAddr=0x43, freez=1 -> next cycle: instruction=0, PCOut=0, flushOut=1, imem_addr=0x40; the following cycle: word at 0x40 and flushOut=0.
REQ-033 imem_ack=0 for 3 cycles, freez=0 -> three NOP bubbles with flushOut=0 and imem_addr stable; the word is delivered on the first ack.
REQ-034 rst low during S_HOLD -> outputs zero immediately without a clock; after release, imem_addr=RESET_PC and the buffered word is never delivered.
REQ-035 RESET_PC=0xFFFF_FFFC, ack=1 -> first IF/ID load has PCOut=0, and the next imem_addr is 0.
